// File: rtl/mem_responder.sv
// Multicycle memory responder. Accepts one read or write at a time from the
// multicycle controller. A valid request completes LATENCY cycles later with
// a one-cycle mem_ready strobe. A misaligned, out-of-range or read+write
// request produces a one-cycle mem_ready+mem_err strobe instead.
// A backdoor port (ld_*) preloads the word array in any state.
module mem_responder #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic [31:0] rdata,
  output logic        mem_ready,
  output logic        mem_err
);

  localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);
  localparam logic [29:0] WORDS    = 30'(DEPTH);

  typedef enum logic [1:0] { IDLE, BUSY, DONE, ERR } state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic             write_q;
  logic [31:0]      mem [DEPTH];

  logic             one_req;
  logic             both_req;
  logic             addr_bad;
  logic             req_ok;
  logic             ld_ok;
  logic [IDX_W-1:0] ld_idx;
  logic             ld_lsb_unused;

  logic             commit;
  logic             commit_write;
  logic [IDX_W-1:0] commit_idx;
  logic [31:0]      commit_wdata;

  assign one_req  = mem_read ^ mem_write;
  assign both_req = mem_read & mem_write;
  assign addr_bad = (addr[1:0] != 2'b00) || (addr[31:2] >= WORDS);
  assign req_ok   = one_req && !addr_bad;

  // Backdoor byte address: low two bits carry no information.
  assign ld_ok         = (ld_addr[31:2] < WORDS);
  assign ld_idx        = ld_addr[IDX_W+1:2];
  assign ld_lsb_unused = ^ld_addr[1:0];

  // Outputs are pure decodes of the state register.
  assign mem_ready = (state == DONE) || (state == ERR);
  assign mem_err   = (state == ERR);

  // Select the transaction committing on this edge: either straight from the
  // inputs (single-cycle latency) or from the captured request at counter 1.
  always_comb begin
    commit       = 1'b0;
    commit_write = write_q;
    commit_idx   = idx_q;
    commit_wdata = wdata_q;
    if ((LATENCY == 1) && (state == IDLE) && req_ok) begin
      commit       = 1'b1;
      commit_write = mem_write;
      commit_idx   = addr[IDX_W+1:2];
      commit_wdata = wdata;
    end else if ((state == BUSY) && (cnt == 4'd1)) begin
      commit = 1'b1;
    end
  end

  // Transaction FSM: request capture, latency countdown, read data return.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      rdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (both_req) begin
            state <= ERR;
          end else if (one_req) begin
            if (addr_bad) begin
              state <= ERR;
            end else begin
              idx_q   <= addr[IDX_W+1:2];
              wdata_q <= wdata;
              write_q <= mem_write;
              cnt     <= CNT_LOAD;
              state   <= (LATENCY == 1) ? DONE : BUSY;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= DONE;
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
      if (commit && !commit_write) rdata <= mem[commit_idx];
    end
  end

  // Array writes. The backdoor is written first, so a transaction write to
  // the same word on the same edge takes precedence. No writes on a reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (ld_en && ld_ok) mem[ld_idx] <= ld_data;
      if (commit && commit_write) mem[commit_idx] <= commit_wdata;
    end
  end

endmodule
